// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcodes, forwarding selects, FSM states, source-use decode
// Purpose: constants and helpers shared by the hazard controller and Decode.
// Ports: none (package).
package pipe_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_ADDI   = 4'd3;
  localparam logic [3:0] OP_SHLLI  = 4'd4;
  localparam logic [3:0] OP_SHRLI  = 4'd5;
  localparam logic [3:0] OP_JUMP   = 4'd6;
  localparam logic [3:0] OP_JUMPL  = 4'd7;
  localparam logic [3:0] OP_JUMPG  = 4'd8;
  localparam logic [3:0] OP_JUMPE  = 4'd9;
  localparam logic [3:0] OP_JUMPNE = 4'd10;
  localparam logic [3:0] OP_CMP    = 4'd11;
  localparam logic [3:0] OP_LOAD   = 4'd12;
  localparam logic [3:0] OP_LOADI  = 4'd13;
  localparam logic [3:0] OP_STORE  = 4'd14;
  localparam logic [3:0] OP_MOV    = 4'd15;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  // Returns {reads_src2, reads_src1} for an opcode.
  function automatic logic [1:0] src_use(input logic [3:0] op);
    logic [1:0] u;
    u = 2'b00;
    case (op)
      OP_SUB, OP_ADD, OP_CMP, OP_STORE:        u = 2'b11;
      OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOAD:    u = 2'b01;
      OP_JUMP, OP_MOV:                         u = 2'b10;
      default:                                 u = 2'b00;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-stage <-> hazard controller signal bundle
// Purpose: groups stage status inputs and stall/flush/forward controls.
// Ports: master = pipeline stages (drive status, receive controls);
//        slave  = hazard controller (receives status, drives controls).
interface pipe_hazard_ctrl_if #(
  parameter int REG_IDX_W = 6,
  parameter int CNT_W     = 16
);
  logic                 id_valid;
  logic [3:0]           id_op;
  logic [REG_IDX_W-1:0] id_src1;
  logic [REG_IDX_W-1:0] id_src2;
  logic                 ex_valid;
  logic                 ex_we;
  logic [3:0]           ex_op;
  logic [REG_IDX_W-1:0] ex_dest;
  logic                 br_taken;
  logic                 mem_we;
  logic [REG_IDX_W-1:0] mem_dest;
  logic                 mem_req;
  logic                 mem_ready;

  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 id_ex_stall;
  logic                 ex_mem_stall;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic                 timeout_err;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output id_valid, id_op, id_src1, id_src2, ex_valid, ex_we, ex_op, ex_dest,
           br_taken, mem_we, mem_dest, mem_req, mem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
           id_ex_bubble, fwd_a, fwd_b, timeout_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_op, id_src1, id_src2, ex_valid, ex_we, ex_op, ex_dest,
           br_taken, mem_we, mem_dest, mem_req, mem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
           id_ex_bubble, fwd_a, fwd_b, timeout_err, stall_cnt
  );
endinterface

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - operand forwarding select for one source operand
// Purpose: picks register file, Execute result or Memory result for one source.
// Ports: i_ex_valid/i_ex_we/i_ex_op/i_ex_dest (Execute), i_mem_we/i_mem_dest
//        (Memory), i_src (Decode source index), o_sel (2-bit select).
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_IDX_W = 6
) (
  input  logic                 i_ex_valid,
  input  logic                 i_ex_we,
  input  logic [3:0]           i_ex_op,
  input  logic [REG_IDX_W-1:0] i_ex_dest,
  input  logic                 i_mem_we,
  input  logic [REG_IDX_W-1:0] i_mem_dest,
  input  logic [REG_IDX_W-1:0] i_src,
  output logic [1:0]           o_sel
);
  // A LOAD in Execute has no data yet; it is picked up from Memory a cycle later.
  always_comb begin
    o_sel = FWD_RF;
    if (i_ex_valid && i_ex_we && (i_ex_op != OP_LOAD) && (i_ex_dest == i_src)) begin
      o_sel = FWD_EX;
    end else if (i_mem_we && (i_mem_dest == i_src)) begin
      o_sel = FWD_MEM;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller (forward, stall, flush, freeze)
// Purpose: sequences Decode/Execute/Memory: forwarding, load-use bubbles,
//          taken-jump flushes, memory-not-ready freezes with timeout.
// Ports: clk, rst_n (async active-low), bus (pipe_hazard_ctrl_if.slave).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_IDX_W   = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [1:0] w_use;
  logic       w_load_use;
  logic       w_mem_miss;
  logic       w_wait_limit;
  logic       w_freeze;
  logic       w_flush;
  logic       w_bubble;
  logic       w_lu_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_use = src_use(bus.id_op);

  assign w_load_use = bus.id_valid && bus.ex_valid && (bus.ex_op == OP_LOAD) &&
                      ((w_use[0] && (bus.ex_dest == bus.id_src1)) ||
                       (w_use[1] && (bus.ex_dest == bus.id_src2)));

  assign w_mem_miss   = bus.mem_req && !bus.mem_ready;
  assign w_wait_limit = (r_wcnt == WCNT_W'(MEM_TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mem_miss)         w_next_state = ST_MEM_WAIT;
        else if (bus.br_taken)  w_next_state = ST_RUN;
        else if (w_load_use)    w_next_state = ST_LOAD_STALL;
      end
      ST_LOAD_STALL: w_next_state = ST_RUN;
      ST_MEM_WAIT: begin
        if (bus.mem_ready || w_wait_limit) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // Output logic: memory freeze > taken jump > load-use
  always_comb begin
    w_freeze   = 1'b0;
    w_flush    = 1'b0;
    w_bubble   = 1'b0;
    w_lu_stall = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_miss) begin
          w_freeze = 1'b1;
        end else if (bus.br_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (w_load_use) begin
          w_lu_stall = 1'b1;
          w_bubble   = 1'b1;
        end
      end
      ST_LOAD_STALL: begin
        if (bus.br_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // The timeout cycle itself releases the pipeline.
        w_freeze = !bus.mem_ready && !w_wait_limit;
      end
      default: ;
    endcase
  end

  assign bus.pc_stall     = rst_n && (w_freeze || w_lu_stall);
  assign bus.if_id_stall  = rst_n && (w_freeze || w_lu_stall);
  assign bus.id_ex_stall  = rst_n && w_freeze;
  assign bus.ex_mem_stall = rst_n && w_freeze;
  assign bus.if_id_flush  = rst_n && w_flush;
  assign bus.id_ex_bubble = rst_n && w_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if ((r_state == ST_MEM_WAIT) && (w_next_state == ST_MEM_WAIT)) begin
      r_wcnt <= r_wcnt + 1'b1;
    end else begin
      r_wcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if ((r_state == ST_MEM_WAIT) && !bus.mem_ready && w_wait_limit) begin
      r_timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((w_freeze || w_lu_stall) && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
  assign bus.stall_cnt   = r_stall_cnt;

  fwd_select #(.REG_IDX_W(REG_IDX_W)) u_fwd_a (
    .i_ex_valid (bus.ex_valid),
    .i_ex_we    (bus.ex_we),
    .i_ex_op    (bus.ex_op),
    .i_ex_dest  (bus.ex_dest),
    .i_mem_we   (bus.mem_we),
    .i_mem_dest (bus.mem_dest),
    .i_src      (bus.id_src1),
    .o_sel      (w_fwd_a)
  );

  fwd_select #(.REG_IDX_W(REG_IDX_W)) u_fwd_b (
    .i_ex_valid (bus.ex_valid),
    .i_ex_we    (bus.ex_we),
    .i_ex_op    (bus.ex_op),
    .i_ex_dest  (bus.ex_dest),
    .i_mem_we   (bus.mem_we),
    .i_mem_dest (bus.mem_dest),
    .i_src      (bus.id_src2),
    .o_sel      (w_fwd_b)
  );

  assign bus.fwd_a = rst_n ? w_fwd_a : FWD_RF;
  assign bus.fwd_b = rst_n ? w_fwd_b : FWD_RF;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_bubble}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LU   = 6'b110001;
  localparam logic [5:0] S_BR   = 6'b000011;
  localparam logic [5:0] S_MEM  = 6'b111100;

  logic clk;
  logic rst_n;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  pipe_hazard_ctrl_if #(.REG_IDX_W(6), .CNT_W(16)) bus ();

  pipe_hazard_ctrl #(.REG_IDX_W(6), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [5:0] ctl;
  assign ctl = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                bus.if_id_flush, bus.id_ex_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_valid = 0; bus.id_op = OP_NOP; bus.id_src1 = 0; bus.id_src2 = 0;
    bus.ex_valid = 0; bus.ex_we = 0; bus.ex_op = OP_NOP; bus.ex_dest = 0;
    bus.br_taken = 0; bus.mem_we = 0; bus.mem_dest = 0;
    bus.mem_req = 0; bus.mem_ready = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // LOAD r4 in Execute, ADD r1,r4 in Decode
  task automatic set_load_use();
    bus.ex_valid = 1; bus.ex_we = 1; bus.ex_op = OP_LOAD; bus.ex_dest = 6'd4;
    bus.id_valid = 1; bus.id_op = OP_ADD; bus.id_src1 = 6'd1; bus.id_src2 = 6'd4;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_load_use();
    bus.mem_req = 1; bus.mem_ready = 0; bus.mem_we = 1; bus.mem_dest = 6'd1;
    #1;
    checks++; if (ctl !== S_NONE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, S_NONE); end
    checks++; if (bus.fwd_a !== FWD_RF) begin errors++; $display("FAIL reset_fwd_a: got %b expected %b", bus.fwd_a, FWD_RF); end
    checks++; if (bus.fwd_b !== FWD_RF) begin errors++; $display("FAIL reset_fwd_b: got %b expected %b", bus.fwd_b, FWD_RF); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", bus.timeout_err); end
    idle();
    @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic test_ex_forward();
    idle();
    bus.ex_valid = 1; bus.ex_we = 1; bus.ex_op = OP_ADD; bus.ex_dest = 6'd3;
    bus.id_valid = 1; bus.id_op = OP_SUB; bus.id_src1 = 6'd5; bus.id_src2 = 6'd3;
    bus.id_src1 = 6'd3;
    bus.mem_we = 1; bus.mem_dest = 6'd3;  // Execute must win over Memory
    #1;
    checks++; if (bus.fwd_a !== FWD_EX) begin errors++; $display("FAIL ex_fwd_a: got %b expected %b", bus.fwd_a, FWD_EX); end
    checks++; if (bus.fwd_b !== FWD_EX) begin errors++; $display("FAIL ex_fwd_b: got %b expected %b", bus.fwd_b, FWD_EX); end
    checks++; if (ctl !== S_NONE) begin errors++; $display("FAIL ex_fwd_ctl: got %b expected %b", ctl, S_NONE); end
    step();
    checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL ex_fwd_stall_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt); end
  endtask

  task automatic test_mem_forward();
    idle();
    // src1 from Memory, src2 = r0 from Execute (index 0 is an ordinary register)
    bus.ex_valid = 1; bus.ex_we = 1; bus.ex_op = OP_ADD; bus.ex_dest = 6'd0;
    bus.mem_we = 1; bus.mem_dest = 6'd7;
    bus.id_src1 = 6'd7; bus.id_src2 = 6'd0;
    #1;
    checks++; if (bus.fwd_a !== FWD_MEM) begin errors++; $display("FAIL mem_fwd_a: got %b expected %b", bus.fwd_a, FWD_MEM); end
    checks++; if (bus.fwd_b !== FWD_EX) begin errors++; $display("FAIL r0_fwd_b: got %b expected %b", bus.fwd_b, FWD_EX); end
    // LOAD in Execute never forwards; Memory match takes it; nothing matches src2
    bus.ex_op = OP_LOAD; bus.ex_dest = 6'd5; bus.mem_dest = 6'd5;
    bus.id_src1 = 6'd5; bus.id_src2 = 6'd9;
    #1;
    checks++; if (bus.fwd_a !== FWD_MEM) begin errors++; $display("FAIL load_no_ex_fwd_a: got %b expected %b", bus.fwd_a, FWD_MEM); end
    checks++; if (bus.fwd_b !== FWD_RF) begin errors++; $display("FAIL rf_fwd_b: got %b expected %b", bus.fwd_b, FWD_RF); end
    idle();
    #1;
  endtask

  task automatic test_load_use();
    logic [3:0] ops  [4] = '{OP_MOV, OP_JUMPE, OP_STORE, OP_ADD};
    logic [5:0] s1   [4] = '{6'd4, 6'd4, 6'd4, 6'd4};
    logic [5:0] s2   [4] = '{6'd9, 6'd4, 6'd9, 6'd9};
    logic       vld  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] exps [4] = '{S_NONE, S_NONE, S_LU, S_NONE};
    idle();
    set_load_use();
    #1;
    checks++; if (ctl !== S_LU) begin errors++; $display("FAIL lu_bubble: got %b expected %b", ctl, S_LU); end
    step();
    exp_cnt++;
    // LOAD_STALL: same Execute contents must not re-trigger; Memory forwards r4
    bus.mem_we = 1; bus.mem_dest = 6'd4;
    #1;
    checks++; if (ctl !== S_NONE) begin errors++; $display("FAIL lu_suppressed: got %b expected %b", ctl, S_NONE); end
    checks++; if (bus.fwd_b !== FWD_MEM) begin errors++; $display("FAIL lu_fwd_b: got %b expected %b", bus.fwd_b, FWD_MEM); end
    idle();
    step();
    checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt); end
    // Source-use decode: only sources the opcode reads can create a hazard
    for (int i = 0; i < 4; i++) begin
      bus.ex_valid = 1; bus.ex_we = 1; bus.ex_op = OP_LOAD; bus.ex_dest = 6'd4;
      bus.id_valid = vld[i]; bus.id_op = ops[i]; bus.id_src1 = s1[i]; bus.id_src2 = s2[i];
      #1;
      checks++; if (ctl !== exps[i]) begin errors++; $display("FAIL lu_decode[%0d]: got %b expected %b", i, ctl, exps[i]); end
    end
    idle();
    #1;
  endtask

  task automatic test_branch();
    idle();
    set_load_use();
    bus.br_taken = 1;
    #1;
    checks++; if (ctl !== S_BR) begin errors++; $display("FAIL br_beats_lu: got %b expected %b", ctl, S_BR); end
    step();
    // still RUN: the same hazard without a jump must bubble now
    bus.br_taken = 0;
    #1;
    checks++; if (ctl !== S_LU) begin errors++; $display("FAIL br_stays_run: got %b expected %b", ctl, S_LU); end
    step();
    exp_cnt++;
    bus.br_taken = 1;  // jump resolved while in LOAD_STALL
    #1;
    checks++; if (ctl !== S_BR) begin errors++; $display("FAIL br_in_lu_stall: got %b expected %b", ctl, S_BR); end
    idle();
    step();
    checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL br_stall_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt); end
  endtask

  task automatic test_mem_wait();
    idle();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.br_taken = (i == 1);  // ignored while frozen
      #1;
      checks++; if (ctl !== S_MEM) begin errors++; $display("FAIL mem_freeze[%0d]: got %b expected %b", i, ctl, S_MEM); end
      step();
    end
    bus.br_taken = 0; bus.mem_ready = 1;
    #1;
    checks++; if (ctl !== S_NONE) begin errors++; $display("FAIL mem_release: got %b expected %b", ctl, S_NONE); end
    step();
    exp_cnt += 3;
    idle();
    #1;
    checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mem_stall_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL mem_no_timeout: got %b expected 0", bus.timeout_err); end
  endtask

  task automatic test_timeout();
    idle();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (ctl !== S_MEM) begin errors++; $display("FAIL to_freeze[%0d]: got %b expected %b", i, ctl, S_MEM); end
      step();
    end
    #1;
    checks++; if (ctl !== S_NONE) begin errors++; $display("FAIL to_release: got %b expected %b", ctl, S_NONE); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b expected 0", bus.timeout_err); end
    bus.mem_req = 0;
    step();
    exp_cnt += 16;
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b expected 1", bus.timeout_err); end
    checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL to_stall_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt); end
    set_load_use();  // only RUN reacts to a load-use hazard
    #1;
    checks++; if (ctl !== S_LU) begin errors++; $display("FAIL to_back_in_run: got %b expected %b", ctl, S_LU); end
    idle();
    step(); step(); step();
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b expected 1", bus.timeout_err); end
  endtask

  task automatic test_reset_mid_wait();
    idle();
    bus.mem_req = 1; bus.mem_ready = 0;
    bus.mem_we = 1; bus.mem_dest = 6'd2; bus.id_src1 = 6'd2;
    step(); step(); step();
    rst_n = 0;
    #1;
    checks++; if (ctl !== S_NONE) begin errors++; $display("FAIL rst_mid_ctl: got %b expected %b", ctl, S_NONE); end
    checks++; if (bus.fwd_a !== FWD_RF) begin errors++; $display("FAIL rst_mid_fwd_a: got %b expected %b", bus.fwd_a, FWD_RF); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b expected 0", bus.timeout_err); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", bus.stall_cnt); end
    idle();
    bus.mem_ready = 0;  // a retained MEM_WAIT would freeze here
    @(posedge clk);
    #1 rst_n = 1;
    #1;
    checks++; if (ctl !== S_NONE) begin errors++; $display("FAIL rst_mid_state: got %b expected %b", ctl, S_NONE); end
    step();
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt_after: got %0d expected 0", bus.stall_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
